roulette_judge: RTL and testbench
=================================

Name: roulette_judge

Overview:
- Input-side counterpart of the HEX roulette. It reads the rotating segment pattern on the display and stops it when the player presses a pushbutton.
- On a debounced press it captures the current position, decodes it to a binary index, compares it against a target and raises `freeze` so the roulette holds.
- A second debounced press releases the roulette and clears the result.
- Sits between `KEY[n]` / the roulette's `HEX0` drive and `LEDR` / top-level indicators.

Parameters:
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable synchronized cycles needed to accept a press or release edge (20 ms at 50 MHz); must be >= 2.
- `CNT_W`, 20: debounce counter width; must satisfy 2^CNT_W >= `DEBOUNCE_CYCLES`.
- `TARGET`, 3'd0: winning segment index, 0..5.

Ports:
- `clk`  in  1  system clock (`CLOCK_50`).
- `nrst`  in  1  reset, asynchronous, active-low.
- `seg_n`  in  7  active-low segment pattern from the roulette. Bit 6 (g) is nominally 1; bits 5:0 are inverted one-hot.
- `key_n`  in  1  raw pushbutton, active-low, asynchronous to `clk`, bouncing.
- `freeze`  out  1  1 = roulette must hold its position.
- `pos`  out  3  captured index 0..5; 3'd7 = invalid capture.
- `pos_valid`  out  1  1 while a captured result is held.
- `hit`  out  1  `pos_valid` && `pos` == `TARGET`.
- `err`  out  1  the captured pattern was not legal.

Behaviour:
- Reset (async, `nrst` low): state RUN, counter 0, both sync flops 1, `freeze` 0, `pos` 3'd7, `pos_valid` 0, `hit` 0, `err` 0.
- `key_n` passes through a 2-flop synchronizer (reset to 1), giving `key_s`. All logic uses `key_s`; raw `key_n` is never used.
- Debounce counter:
  - Increments while `key_s` matches the level the current state is waiting for.
  - Clears on any mismatch and on every state change.
  - An edge is accepted in the cycle the counter equals `DEBOUNCE_CYCLES`-1 while still matching.
- States:
  - RUN: `freeze` 0. `key_s` == 0 -> PRESS_DB.
  - PRESS_DB: waits for `key_s` == 0.
    - `key_s` == 1 before acceptance -> RUN (bounce rejected, nothing captured).
    - On acceptance, `seg_n` is sampled that cycle -> HOLD.
    - `freeze`, `pos`, `pos_valid`, `hit` and `err` update in the following cycle (registered outputs, 1-cycle latency).
  - HOLD: `freeze` 1, result held. Waits for a debounced release (`key_s` == 1) -> STOPPED.
  - STOPPED: `freeze` 1, result held. Waits for a debounced press -> RESUME.
  - RESUME: on entry, `pos_valid`, `hit` and `err` are cleared and `pos` is set to 3'd7; `freeze` stays 1. Waits for a debounced release -> RUN, with `freeze` deasserting the cycle after acceptance.
- Decode at capture: `oh` = ~`seg_n`[5:0].
  - Legal when exactly one bit of `oh` is set and `seg_n`[6] == 1. Then `pos` = index of the set bit, `err` = 0, and `hit` = (`pos` == `TARGET`).
  - Illegal (zero bits, more than one bit, or g lit): `pos` = 3'd7, `err` = 1, `hit` = 0. `pos_valid` is still 1.
- `seg_n` is sampled only at capture; changes while `freeze` = 1 are ignored.
- Counter saturates, no wrap: after acceptance the state changes, so the counter is cleared before it can overflow.
- Reset mid-operation: immediate return to the reset values above, including during any debounce window.
- A press bouncing across the synchronizer produces at most one capture per debounced press/release pair.

Optional Feature:
- `ROULETTE_JUDGE_SCORE_EN`
  - Defined: adds output `score` [3:0], reset to 0. It increments by 1 in the cycle `hit` rises, saturates at 15, and is cleared only by `nrst` (RESUME does not clear it).
  - Undefined: no `score` port, no score register. All other behaviour is identical.

Test Plan:
- Bench uses `DEBOUNCE_CYCLES`=4.
- Reset: hold `nrst`=0 -> `freeze`=0, `pos`=7, `pos_valid`=0, `hit`=0, `err`=0; assert `nrst` low asynchronously mid-HOLD -> same values with no clock edge needed.
- Clean press, `TARGET`=3: `seg_n`=7'b1110111, `key_n` low for 10 cycles -> `freeze`=1, `pos`=3, `pos_valid`=1, `hit`=1, `err`=0 exactly 2 (sync) + 4 + 1 cycles after the `key_n` fall.
- Bounce rejection: `key_n` low 2 cycles, high 1, low 2, high -> state stays RUN, `freeze` 0, `pos_valid` 0.
- Illegal pattern: `seg_n`=7'b1110011 at capture -> `pos`=7, `err`=1, `hit`=0, `pos_valid`=1; `seg_n`=7'b0111110 (g lit) -> `err`=1.
- Full cycle: press/release -> STOPPED with `pos`=5 (`seg_n`=7'b1011111), `hit`=0; change `seg_n` -> `pos` unchanged; press -> `pos_valid`=0, `pos`=7; release -> `freeze`=0 and state RUN.
- With `ROULETTE_JUDGE_SCORE_EN`: 17 consecutive hit rounds -> `score` goes 1..15 and stays 15; miss rounds leave `score` unchanged.

Source files
------------

// File: rtl/roulette_judge.sv
// roulette_judge: watches the HEX roulette segment drive and stops it on a
// debounced pushbutton press. It captures the lit segment, decodes it to an
// index, flags a hit against TARGET and holds the roulette until a second
// debounced press/release pair lets it run again.
// Optional feature macro: ROULETTE_JUDGE_SCORE_EN adds a saturating 4-bit
// hit counter on output 'score'.
module roulette_judge #(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter int         CNT_W           = 20,
    parameter logic [2:0] TARGET          = 3'd0
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [6:0] seg_n,
    input  logic       key_n,
    output logic       freeze,
    output logic [2:0] pos,
    output logic       pos_valid,
    output logic       hit,
`ifdef ROULETTE_JUDGE_SCORE_EN
    output logic [3:0] score,
`endif
    output logic       err
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_PRESS_DB,
        ST_HOLD,
        ST_STOPPED,
        ST_RESUME
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] dbCnt_q;
    logic             keyMeta_q;
    logic             keySync_q;
    logic             freeze_q;
    logic [2:0]       pos_q;
    logic             posValid_q;
    logic             hit_q;
    logic             err_q;
`ifdef ROULETTE_JUDGE_SCORE_EN
    logic [3:0]       score_q;
`endif

    logic             waitLevel;
    logic             keyMatch;
    logic             cntDone;

    logic [5:0]       oh;
    logic [2:0]       ones;
    logic [2:0]       idx;
    logic             legal;
    logic [2:0]       pos_d;
    logic             hit_d;
    logic             err_d;

    // Two-flop synchronizer; idles at 1 so a reset never looks like a press.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            keyMeta_q <= 1'b1;
            keySync_q <= 1'b1;
        end else begin
            keyMeta_q <= key_n;
            keySync_q <= keyMeta_q;
        end
    end

    // Level each debouncing state is waiting for: releases in HOLD/RESUME, presses otherwise.
    always_comb begin
        waitLevel = (state_q == ST_HOLD) || (state_q == ST_RESUME);
        keyMatch  = (keySync_q == waitLevel);
        cntDone   = keyMatch && (dbCnt_q == CNT_LAST);
    end

    // Decode the inverted one-hot segment pattern into an index plus legality.
    always_comb begin
        oh   = ~seg_n[5:0];
        ones = 3'd0;
        idx  = 3'd7;
        for (int i = 0; i < 6; i++) begin
            if (oh[i]) begin
                ones = ones + 3'd1;
                idx  = 3'(i);
            end
        end
        legal = (ones == 3'd1) && seg_n[6];
        pos_d = legal ? idx : 3'd7;
        err_d = !legal;
        hit_d = legal && (idx == TARGET);
    end

    // Judge FSM with debounce counter and registered result outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_RUN;
            dbCnt_q    <= '0;
            freeze_q   <= 1'b0;
            pos_q      <= 3'd7;
            posValid_q <= 1'b0;
            hit_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef ROULETTE_JUDGE_SCORE_EN
            score_q    <= 4'd0;
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    dbCnt_q  <= '0;
                    freeze_q <= 1'b0;
                    if (!keySync_q) begin
                        state_q <= ST_PRESS_DB;
                    end
                end

                ST_PRESS_DB: begin
                    if (!keyMatch) begin
                        state_q <= ST_RUN;
                        dbCnt_q <= '0;
                    end else if (cntDone) begin
                        state_q    <= ST_HOLD;
                        dbCnt_q    <= '0;
                        freeze_q   <= 1'b1;
                        pos_q      <= pos_d;
                        posValid_q <= 1'b1;
                        hit_q      <= hit_d;
                        err_q      <= err_d;
`ifdef ROULETTE_JUDGE_SCORE_EN
                        if (hit_d && !hit_q && (score_q != 4'd15)) begin
                            score_q <= score_q + 4'd1;
                        end
`endif
                    end else begin
                        dbCnt_q <= dbCnt_q + CNT_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (!keyMatch) begin
                        dbCnt_q <= '0;
                    end else if (cntDone) begin
                        state_q <= ST_STOPPED;
                        dbCnt_q <= '0;
                    end else begin
                        dbCnt_q <= dbCnt_q + CNT_W'(1);
                    end
                end

                ST_STOPPED: begin
                    if (!keyMatch) begin
                        dbCnt_q <= '0;
                    end else if (cntDone) begin
                        state_q    <= ST_RESUME;
                        dbCnt_q    <= '0;
                        pos_q      <= 3'd7;
                        posValid_q <= 1'b0;
                        hit_q      <= 1'b0;
                        err_q      <= 1'b0;
                    end else begin
                        dbCnt_q <= dbCnt_q + CNT_W'(1);
                    end
                end

                ST_RESUME: begin
                    if (!keyMatch) begin
                        dbCnt_q <= '0;
                    end else if (cntDone) begin
                        state_q  <= ST_RUN;
                        dbCnt_q  <= '0;
                        freeze_q <= 1'b0;
                    end else begin
                        dbCnt_q <= dbCnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_RUN;
                    dbCnt_q <= '0;
                end
            endcase
        end
    end

    assign freeze    = freeze_q;
    assign pos       = pos_q;
    assign pos_valid = posValid_q;
    assign hit       = hit_q;
    assign err       = err_q;
`ifdef ROULETTE_JUDGE_SCORE_EN
    assign score     = score_q;
`endif

endmodule

// File: tb/tb_roulette_judge.sv
// Testbench for roulette_judge with a short debounce window. Expected capture
// results are queued when a press is driven and popped when freeze rises.
// Score checks are compiled only with ROULETTE_JUDGE_SCORE_EN.
module tb_roulette_judge;

    localparam int         DB     = 4;
    localparam int         CNT_W  = 3;
    localparam logic [2:0] TARGET = 3'd3;

    logic       clk = 1'b0;
    logic       nrst;
    logic [6:0] seg_n;
    logic       key_n;
    logic       freeze;
    logic [2:0] pos;
    logic       pos_valid;
    logic       hit;
    logic       err;
`ifdef ROULETTE_JUDGE_SCORE_EN
    logic [3:0] score;
`endif

    typedef struct {
        logic [2:0] pos;
        logic       hit;
        logic       err;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    int   expScore = 0;

    roulette_judge #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CNT_W),
        .TARGET         (TARGET)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .seg_n    (seg_n),
        .key_n    (key_n),
        .freeze   (freeze),
        .pos      (pos),
        .pos_valid(pos_valid),
        .hit      (hit),
`ifdef ROULETTE_JUDGE_SCORE_EN
        .score    (score),
`endif
        .err      (err)
    );

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] seg, input logic key);
        seg_n = seg;
        key_n = key;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press from RUN, measure capture latency, compare against the queued expectation
    task automatic pressCapture(input logic [6:0] seg, input logic [2:0] p, input logic h,
                                input logic e, input string tag);
        exp_t item;
        exp_t want;
        int   cyc;
        item.pos = p;
        item.hit = h;
        item.err = e;
        expQ.push_back(item);
        applyStimulus(seg, 1'b0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!freeze && cyc < 50);
        checkOutput({tag, "_latency"}, cyc, 7);
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue"}, 0, 1);
        end else begin
            want = expQ.pop_front();
            checkOutput({tag, "_freeze"}, freeze, 1);
            checkOutput({tag, "_pos"}, pos, want.pos);
            checkOutput({tag, "_valid"}, pos_valid, 1);
            checkOutput({tag, "_hit"}, hit, want.hit);
            checkOutput({tag, "_err"}, err, want.err);
`ifdef ROULETTE_JUDGE_SCORE_EN
            if (want.hit && expScore < 15) expScore++;
            checkOutput({tag, "_score"}, score, expScore);
`endif
        end
        waitCycles(3);
    endtask

    // Release, prove the result is held and seg_n ignored, then press/release to resume
    task automatic finishRound(input logic [2:0] p, input string tag);
        int cyc;
        applyStimulus(seg_n, 1'b1);
        waitCycles(10);
        checkOutput({tag, "_stopFreeze"}, freeze, 1);
        checkOutput({tag, "_stopValid"}, pos_valid, 1);
        applyStimulus(7'b1111110, 1'b1);
        waitCycles(3);
        checkOutput({tag, "_heldPos"}, pos, p);
        applyStimulus(seg_n, 1'b0);
        waitCycles(10);
        checkOutput({tag, "_resValid"}, pos_valid, 0);
        checkOutput({tag, "_resPos"}, pos, 7);
        checkOutput({tag, "_resHit"}, hit, 0);
        checkOutput({tag, "_resErr"}, err, 0);
        checkOutput({tag, "_resFreeze"}, freeze, 1);
`ifdef ROULETTE_JUDGE_SCORE_EN
        checkOutput({tag, "_resScore"}, score, expScore);
`endif
        applyStimulus(seg_n, 1'b1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (freeze && cyc < 50);
        checkOutput({tag, "_relLatency"}, cyc, 6);
        waitCycles(2);
    endtask

    initial begin
        int seen;

        nrst = 1'b0;
        applyStimulus(7'b1111111, 1'b1);
        waitCycles(3);
        $display("[TB] reset values");
        checkOutput("rst_freeze", freeze, 0);
        checkOutput("rst_pos", pos, 7);
        checkOutput("rst_valid", pos_valid, 0);
        checkOutput("rst_hit", hit, 0);
        checkOutput("rst_err", err, 0);
        nrst = 1'b1;
        waitCycles(2);

        $display("[TB] bounce rejection");
        applyStimulus(7'b1110111, 1'b0);
        waitCycles(2);
        applyStimulus(seg_n, 1'b1);
        waitCycles(1);
        applyStimulus(seg_n, 1'b0);
        waitCycles(2);
        applyStimulus(seg_n, 1'b1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (freeze || pos_valid) seen = 1;
        end
        checkOutput("bounce_noCapture", seen, 0);
        checkOutput("bounce_pos", pos, 7);

        $display("[TB] clean hit, illegal patterns, miss at pos 5");
        pressCapture(7'b1110111, 3'd3, 1'b1, 1'b0, "hit3");
        finishRound(3'd3, "hit3");
        pressCapture(7'b1110011, 3'd7, 1'b0, 1'b1, "twoBits");
        finishRound(3'd7, "twoBits");
        pressCapture(7'b0111110, 3'd7, 1'b0, 1'b1, "gLit");
        finishRound(3'd7, "gLit");
        pressCapture(7'b1111111, 3'd7, 1'b0, 1'b1, "noBits");
        finishRound(3'd7, "noBits");
        pressCapture(7'b1011111, 3'd5, 1'b0, 1'b0, "pos5");
        finishRound(3'd5, "pos5");

        $display("[TB] async reset mid-HOLD");
        pressCapture(7'b1110111, 3'd3, 1'b1, 1'b0, "preRst");
        #2;
        nrst  = 1'b0;
        key_n = 1'b1;
        #1;
        checkOutput("async_freeze", freeze, 0);
        checkOutput("async_pos", pos, 7);
        checkOutput("async_valid", pos_valid, 0);
        checkOutput("async_hit", hit, 0);
        checkOutput("async_err", err, 0);
        expScore = 0;
`ifdef ROULETTE_JUDGE_SCORE_EN
        checkOutput("async_score", score, 0);
`endif
        @(negedge clk);
        nrst = 1'b1;
        waitCycles(2);

        $display("[TB] repeated hit rounds then a miss");
        for (int r = 0; r < 17; r++) begin
            pressCapture(7'b1110111, 3'd3, 1'b1, 1'b0, $sformatf("hitRound%0d", r));
            finishRound(3'd3, $sformatf("hitRound%0d", r));
        end
        pressCapture(7'b1111101, 3'd1, 1'b0, 1'b0, "missRound");
        finishRound(3'd1, "missRound");
`ifdef ROULETTE_JUDGE_SCORE_EN
        checkOutput("final_score", score, 15);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
